pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised LC-3b inter-stage pipeline register with a valid/ready handshake, synchronous flush with NOP injection, and a saturating stall counter. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance carries PC, instruction word and a stage-specific control payload. It replaces the bare always-load PC/IR register pair, which has no stall, flush or valid tracking.

## Interface
Parameters:
- PAYLOAD_W, 8: width of the stage-specific control payload; legal range 1..64
- CNT_W, 16: width of the stall counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of all held and incoming entries
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  this stage accepts the entry this cycle
- in_pc  in  16  PC of incoming instruction (lc3b_word)
- in_ir  in  16  incoming instruction word (lc3b_word)
- in_payload  in  PAYLOAD_W  incoming control payload
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream stage accepts entry this cycle
- out_pc  out  16  held PC
- out_ir  out  16  held instruction; NOP when out_valid=0
- out_payload  out  PAYLOAD_W  held payload; all-zero when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Main entry holds the word presented downstream. Skid entry exists only with the macro below.
- States (macro set): EMPTY (no entries), FULL (main only), SKID (main plus skid).
  - EMPTY -> FULL on transfer in.
  - FULL -> FULL on simultaneous in and out; main takes the new word.
  - FULL -> EMPTY on out only.
  - FULL -> SKID on in only; the new word goes to skid.
  - SKID -> FULL on out; skid moves to main.
- Without the macro only EMPTY and FULL exist.
- in_ready: with the macro, registered, = (state != SKID). Without the macro, combinational, = !out_valid || out_ready.
- Flush: on the next edge, state = EMPTY and all entries are dropped.
  - Any transfer in during the flush cycle is discarded.
  - A transfer out during the flush cycle is still considered completed.
- Reset has priority over flush. Flush has priority over handshake.
- When out_valid=0: out_ir = LC3B_NOP (16'h0000, BR with no condition codes) and out_payload = 0. out_pc holds its last value.
- stall_cnt increments by 1 each cycle with out_valid && !out_ready. It saturates at all-ones. It clears only on reset; flush does not clear it.

## Timing
- Reset values:
  - out_valid=0, out_pc=16'h0000, out_ir=16'h0000, out_payload=0, stall_cnt=0.
  - in_ready=1 in the cycle after reset deasserts.
- Latency: an entry accepted at edge N is presented (out_valid=1) from edge N on, i.e. one cycle.
- No combinational path in_valid -> out_valid. With the macro, no combinational path out_ready -> in_ready.
- Throughput: one entry per cycle sustained when out_ready=1.
- Full boundary (macro set): in SKID, in_ready=0 for the whole cycle. Upstream must hold its entry.
- Upstream/downstream must hold data stable while valid && !ready. A violation is undefined; the bench asserts against it.
- Reset mid-operation: held entries are lost, with no partial output.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Two-entry skid buffer; in_ready is registered, cutting the backpressure timing chain across stages.
  - Up to one extra entry is absorbed after downstream stalls.
- Undefined:
  - Single entry; in_ready is combinational from out_ready.
  - Area is minimal; SKID state and skid storage are absent.

## Structure
- lc3b_types package:
  - lc3b_word typedef
  - LC3B_NOP constant (16'h0000)
  - enum pipe_state_t {EMPTY, FULL, SKID}
- Per-stage payload structs (e.g. id_ex_ctrl_t) also live in the package; the instance passes $bits of the struct as PAYLOAD_W.
- One sub-module: pipe_sat_counter (CNT_W-wide saturating counter with inc and sync clear), reusable for other performance counters.
- Storage uses plain always_ff, not the generic 16-bit register module, since widths vary.

## Test plan
- Reset held 2 cycles, then released -> out_valid=0, out_ir=16'h0000, stall_cnt=0, in_ready=1.
- Stream in_pc=16'h3000..16'h3006 with in_ir=16'h1021, out_ready=1 -> identical sequence out with 1-cycle latency and no gaps.
- Macro set; FULL with pc=16'h3000; out_ready=0; offer pc=16'h3002 -> accepted, state=SKID, in_ready=0. Then out_ready=1 -> 16'h3000 then 16'h3002 out in order.
- flush together with in_valid (pc=16'h4000) while holding 16'h3000 -> next cycle out_valid=0, out_ir=NOP, and 16'h4000 never appears.
- CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 4'hF and holds. Flush leaves it at 4'hF; reset clears it to 0.
- Reset asserted in SKID state alongside flush=1 -> next cycle EMPTY with all reset values, and stall_cnt=0.

Source files
------------

// File: rtl/lc3b_types.sv
// ============================================================================
// Package : lc3b_types
// Brief   : Shared LC-3b word type, NOP encoding, pipe-register states and payload structs.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // BR with no condition codes set never branches, so all-zero is a true NOP.
    localparam lc3b_word LC3B_NOP = 16'h0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       sel_imm;
    } id_ex_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_sat_counter.sv
// ============================================================================
// Module : pipe_sat_counter
// Brief  : CNT_W-wide counter that increments on inc_i, sticks at all-ones, sync clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module : pipe_stage_reg
// Brief  : LC-3b inter-stage register with valid/ready, flush/NOP injection and
//          a saturating stall counter. PIPE_STAGE_SKID_EN adds a skid entry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import lc3b_types::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  lc3b_word             in_pc,
    input  lc3b_word             in_ir,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output lc3b_word             out_pc,
    output lc3b_word             out_ir,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     stall_cnt
);

    pipe_state_t            state_q, state_d;
    lc3b_word               main_pc_q, main_pc_d;
    lc3b_word               main_ir_q, main_ir_d;
    logic [PAYLOAD_W-1:0]   main_pl_q, main_pl_d;

    logic w_out_valid;
    logic w_xfer_in;
    logic w_xfer_out;

    assign w_out_valid = (state_q != EMPTY);
    assign w_xfer_in   = in_valid && in_ready;
    assign w_xfer_out  = w_out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    lc3b_word             skid_pc_q, skid_pc_d;
    lc3b_word             skid_ir_q, skid_ir_d;
    logic [PAYLOAD_W-1:0] skid_pl_q, skid_pl_d;
    logic                 in_ready_q;

    // Registered from next state so backpressure does not ripple combinationally upstream.
    assign in_ready = in_ready_q;
`else
    assign in_ready = !w_out_valid || out_ready;
`endif

    always_comb begin
        state_d   = state_q;
        main_pc_d = main_pc_q;
        main_ir_d = main_ir_q;
        main_pl_d = main_pl_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_pc_d = skid_pc_q;
        skid_ir_d = skid_ir_q;
        skid_pl_d = skid_pl_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_xfer_in) begin
                        state_d   = FULL;
                        main_pc_d = in_pc;
                        main_ir_d = in_ir;
                        main_pl_d = in_payload;
                    end
                end
                FULL: begin
                    if (w_xfer_in) begin
`ifdef PIPE_STAGE_SKID_EN
                        if (!w_xfer_out) begin
                            state_d   = SKID;
                            skid_pc_d = in_pc;
                            skid_ir_d = in_ir;
                            skid_pl_d = in_payload;
                        end else begin
                            main_pc_d = in_pc;
                            main_ir_d = in_ir;
                            main_pl_d = in_payload;
                        end
`else
                        main_pc_d = in_pc;
                        main_ir_d = in_ir;
                        main_pl_d = in_payload;
`endif
                    end else if (w_xfer_out) begin
                        state_d = EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                SKID: begin
                    if (w_xfer_out) begin
                        state_d   = FULL;
                        main_pc_d = skid_pc_q;
                        main_ir_d = skid_ir_q;
                        main_pl_d = skid_pl_q;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            main_pc_q <= '0;
            main_ir_q <= LC3B_NOP;
            main_pl_q <= '0;
        end else begin
            state_q   <= state_d;
            main_pc_q <= main_pc_d;
            main_ir_q <= main_ir_d;
            main_pl_q <= main_pl_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_pc_q  <= '0;
            skid_ir_q  <= LC3B_NOP;
            skid_pl_q  <= '0;
            in_ready_q <= 1'b1;
        end else begin
            skid_pc_q  <= skid_pc_d;
            skid_ir_q  <= skid_ir_d;
            skid_pl_q  <= skid_pl_d;
            in_ready_q <= (state_d != SKID);
        end
    end
`endif

    assign out_valid   = w_out_valid;
    assign out_pc      = main_pc_q;
    assign out_ir      = w_out_valid ? main_ir_q : LC3B_NOP;
    assign out_payload = w_out_valid ? main_pl_q : '0;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (1'b0),
        .inc_i (w_out_valid && !out_ready),
        .cnt_o (stall_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module : tb_pipe_stage_reg
// Brief  : Directed self-checking bench for pipe_stage_reg (CNT_W=4, PAYLOAD_W=8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;
    import lc3b_types::*;

    localparam int PAYLOAD_W = 8;
    localparam int CNT_W     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    lc3b_word             in_pc;
    lc3b_word             in_ir;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic                 out_ready;
    lc3b_word             out_pc;
    lc3b_word             out_ir;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CNT_W-1:0]     stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_ir       (in_ir),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_ir      (out_ir),
        .out_payload (out_payload),
        .stall_cnt   (stall_cnt)
    );

    // Downstream-facing stability: a stalled entry must not change unless flushed or reset.
    logic                 prev_hold = 1'b0;
    lc3b_word             prev_pc, prev_ir;
    logic [PAYLOAD_W-1:0] prev_pl;
    always @(negedge clk) begin
        if (prev_hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== prev_pc || out_ir !== prev_ir || out_payload !== prev_pl) begin
                errors++;
                $display("FAIL stable_hold: got v=%b pc=%h ir=%h pl=%h, need v=1 pc=%h ir=%h pl=%h",
                         out_valid, out_pc, out_ir, out_payload, prev_pc, prev_ir, prev_pl);
            end
        end
        prev_hold = (out_valid === 1'b1) && (out_ready === 1'b0) && (flush === 1'b0) && (reset === 1'b0);
        prev_pc   = out_pc;
        prev_ir   = out_ir;
        prev_pl   = out_payload;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_ir = '0; in_payload = '0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b need 0", out_valid); end
        checks++; if (out_ir !== 16'h0000) begin errors++; $display("FAIL rst_ir: got %h need 0000", out_ir); end
        checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h need 0000", out_pc); end
        checks++; if (out_payload !== 8'h00) begin errors++; $display("FAIL rst_payload: got %h need 00", out_payload); end
        checks++; if (stall_cnt !== 4'h0) begin errors++; $display("FAIL rst_stall: got %h need 0", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
    endtask

    task automatic test_stream();
        lc3b_word exp_pc;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc     = 16'h3000 + 16'(2 * i);
            in_valid   = 1'b1;
            in_pc      = exp_pc;
            in_ir      = 16'h1021;
            in_payload = 8'(i + 1);
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_ir !== 16'h1021 || out_payload !== 8'(i + 1)) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h ir=%h pl=%h need v=1 pc=%h ir=1021 pl=%h",
                         i, out_valid, out_pc, out_ir, out_payload, exp_pc, 8'(i + 1));
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b need 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ir !== LC3B_NOP || out_payload !== 8'h00) begin
            errors++;
            $display("FAIL stream_drain: got v=%b ir=%h pl=%h need v=0 ir=0000 pl=00", out_valid, out_ir, out_payload);
        end
        checks++; if (out_pc !== 16'h3006) begin errors++; $display("FAIL stream_pc_hold: got %h need 3006", out_pc); end
        checks++; if (stall_cnt !== 4'h0) begin errors++; $display("FAIL stream_stall: got %h need 0", stall_cnt); end
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_skid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 16'h3000; in_ir = 16'h1021; in_payload = 8'hA1;
        tick();
        in_pc = 16'h3002; in_ir = 16'h1022; in_payload = 8'hA2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_full: got %b need 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_skid: got %b need 0", in_ready); end
        checks++; if (out_pc !== 16'h3000 || out_valid !== 1'b1) begin errors++; $display("FAIL skid_head: got v=%b pc=%h need v=1 pc=3000", out_valid, out_pc); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h3002 || out_ir !== 16'h1022 || out_payload !== 8'hA2) begin
            errors++;
            $display("FAIL skid_second: got v=%b pc=%h ir=%h pl=%h need v=1 pc=3002 ir=1022 pl=a2", out_valid, out_pc, out_ir, out_payload);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b need 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain: got %b need 0", out_valid); end
    endtask
`else
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 16'h3000; in_ir = 16'h1021; in_payload = 8'hA1;
        tick();
        in_pc = 16'h3002; in_ir = 16'h1022; in_payload = 8'hA2;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b need 0", in_ready); end
        tick();
        checks++; if (out_pc !== 16'h3000 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got v=%b pc=%h need v=1 pc=3000", out_valid, out_pc); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b need 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h3002 || out_payload !== 8'hA2) begin
            errors++;
            $display("FAIL bp_second: got v=%b pc=%h pl=%h need v=1 pc=3002 pl=a2", out_valid, out_pc, out_payload);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b need 0", out_valid); end
    endtask
`endif

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 16'h3000; in_ir = 16'h1021; in_payload = 8'h11;
        tick();
        flush = 1'b1; in_pc = 16'h4000; in_ir = 16'h5555; in_payload = 8'h44;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_ir !== LC3B_NOP || out_payload !== 8'h00) begin
            errors++;
            $display("FAIL flush_nop: got v=%b ir=%h pl=%h need v=0 ir=0000 pl=00", out_valid, out_ir, out_payload);
        end
        checks++; if (out_pc !== 16'h3000) begin errors++; $display("FAIL flush_pc_hold: got %h need 3000", out_pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_pc === 16'h4000) begin
                errors++;
                $display("FAIL flush_gone_%0d: got v=%b pc=%h need v=0 and pc!=4000", i, out_valid, out_pc);
            end
        end
    endtask

    task automatic test_stall_counter();
        reset = 1'b1;
        tick();
        reset = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 16'h6000; in_ir = 16'h1021; in_payload = 8'h66;
        tick();
        in_valid = 1'b0;
        checks++; if (stall_cnt !== 4'h0) begin errors++; $display("FAIL stall_start: got %h need 0", stall_cnt); end
        repeat (5) tick();
        checks++; if (stall_cnt !== 4'h5) begin errors++; $display("FAIL stall_5: got %h need 5", stall_cnt); end
        repeat (15) tick();
        checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL stall_sat: got %h need f", stall_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (stall_cnt !== 4'hF || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush: got cnt=%h v=%b need cnt=f v=0", stall_cnt, out_valid);
        end
        tick();
        checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL stall_idle: got %h need f", stall_cnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (stall_cnt !== 4'h0) begin errors++; $display("FAIL stall_reset: got %h need 0", stall_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 16'h5000; in_ir = 16'h1234; in_payload = 8'h55;
        tick();
        in_pc = 16'h5002; in_ir = 16'h1236; in_payload = 8'h56;
        tick();
        in_valid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_skid: got in_ready=%b need 0", in_ready); end
`endif
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_pc !== 16'h0000 || out_ir !== 16'h0000 || out_payload !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_out: got v=%b pc=%h ir=%h pl=%h need all zero", out_valid, out_pc, out_ir, out_payload);
        end
        checks++; if (stall_cnt !== 4'h0) begin errors++; $display("FAIL mid_reset_stall: got %h need 0", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b need 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_stream();
`ifdef PIPE_STAGE_SKID_EN
        test_skid();
`else
        test_backpressure();
`endif
        test_flush();
        test_stall_counter();
        test_reset_mid();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
